// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU commands, shift types, FSM states, NZCV indices.
package exe_pkg;

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_MUL = 4'b1010;

   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   localparam int NZCV_N = 3;
   localparam int NZCV_Z = 2;
   localparam int NZCV_C = 1;
   localparam int NZCV_V = 0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } exe_state_e;

endpackage

// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// done is asserted combinationally on the final iteration together with the low DATA_W product bits.
module iter_multiplier #(
   parameter int DATA_W   = 32,
   parameter int MUL_STEP = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [DATA_W-1:0] product
);
   localparam int MUL_CYC = DATA_W / MUL_STEP;
   localparam int CNT_W   = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

   logic [DATA_W-1:0] mcand_r, mplier_r, acc_r, partial_s;
   logic [CNT_W-1:0]  cnt_r;
   logic              active_r;

   assign partial_s = mcand_r * DATA_W'(mplier_r[MUL_STEP-1:0]);
   assign done      = active_r && (cnt_r == CNT_W'(MUL_CYC - 1));
   assign product   = acc_r + partial_s;

   // Digit-serial accumulate; counter wraps to zero on the last digit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcand_r  <= '0;
         mplier_r <= '0;
         acc_r    <= '0;
         cnt_r    <= '0;
         active_r <= 1'b0;
      end else if (abort) begin
         cnt_r    <= '0;
         active_r <= 1'b0;
      end else if (start) begin
         mcand_r  <= a;
         mplier_r <= b;
         acc_r    <= '0;
         cnt_r    <= '0;
         active_r <= 1'b1;
      end else if (active_r) begin
         acc_r    <= acc_r + partial_s;
         mcand_r  <= mcand_r << MUL_STEP;
         mplier_r <= mplier_r >> MUL_STEP;
         cnt_r    <= done ? '0 : cnt_r + CNT_W'(1);
         active_r <= !done;
      end
   end

endmodule

// File: rtl/exe_stage_pipe.sv
// ARM-subset execute stage: operand-2 shifter, ALU with NZCV, branch target adder and an
// iterative multiplier, registered toward MEM behind valid/ready handshakes with flush.
module exe_stage_pipe
   import exe_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int IMM_W    = 24,
   parameter int MUL_STEP = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              wb_en_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic              I,
   input  logic              s_in,
   input  logic [3:0]        exe_command_in,
   input  logic [11:0]       shift_operand,
   input  logic [3:0]        dest,
   input  logic [IMM_W-1:0]  signed_immediate_24,
   input  logic [DATA_W-1:0] PC_in,
   input  logic [DATA_W-1:0] val_rn,
   input  logic [DATA_W-1:0] val_rm,
   input  logic [3:0]        status_reg_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              wb_en_out,
   output logic              mem_read_out,
   output logic              mem_write_out,
   output logic              status_we_out,
   output logic [3:0]        dest_out,
   output logic [3:0]        status_bits_out,
   output logic [DATA_W-1:0] alu_res,
   output logic [DATA_W-1:0] val_rm_out,
   output logic [DATA_W-1:0] branch_address,
   output logic              busy
);
   localparam int SH_W = $clog2(DATA_W);

   exe_state_e        state_r, state_s;
   logic              accept_s, is_mem_s, is_mul_s, mul_start_s, mul_fin_s, mul_done_s;
   logic [DATA_W-1:0] val2_s, res_s, br_s, prod_s;
   logic [DATA_W:0]   sum_s;
   logic              c_s, v_s;
   logic [3:0]        nzcv_s;

   logic              p_wb_r, p_mr_r, p_mw_r, p_s_r;
   logic [3:0]        p_dest_r, p_status_r;
   logic [DATA_W-1:0] p_rm_r, p_br_r;

   function automatic logic [DATA_W-1:0] ror_w(input logic [DATA_W-1:0] x, input logic [SH_W-1:0] n);
      logic [2*DATA_W-1:0] d;
      d = {x, x} >> n;
      return d[DATA_W-1:0];
   endfunction

   assign in_ready    = (state_r == ST_IDLE) && (!out_valid || out_ready);
   assign accept_s    = in_valid && in_ready;
   assign is_mem_s    = mem_read_in || mem_write_in;
   assign is_mul_s    = (exe_command_in == CMD_MUL) && !is_mem_s;
   assign mul_start_s = accept_s && is_mul_s && !flush;
   assign mul_done_s  = mul_fin_s && (state_r == ST_MUL);
   assign br_s        = PC_in + (DATA_W'($signed(signed_immediate_24)) << 2);

   // Second operand: rotated immediate, raw memory offset, or shifted Rm.
   always_comb begin
      val2_s = val_rm;
      if (I) begin
         val2_s = ror_w(DATA_W'(shift_operand[7:0]), SH_W'({shift_operand[11:8], 1'b0}));
      end else if (is_mem_s) begin
         val2_s = DATA_W'(shift_operand);
      end else begin
         case (shift_operand[6:5])
            SH_LSL:  val2_s = val_rm << shift_operand[11:7];
            SH_LSR:  val2_s = val_rm >> shift_operand[11:7];
            SH_ASR:  val2_s = $unsigned($signed(val_rm) >>> shift_operand[11:7]);
            SH_ROR:  val2_s = ror_w(val_rm, SH_W'(shift_operand[11:7]));
            default: val2_s = val_rm;
         endcase
      end
   end

   // ALU; subtraction runs as rn + ~val2 + carry so C means "no borrow".
   always_comb begin
      sum_s = '0;
      res_s = '0;
      c_s   = status_reg_in[NZCV_C];
      v_s   = status_reg_in[NZCV_V];
      if (is_mem_s) begin
         res_s = val_rn + val2_s;
      end else begin
         case (exe_command_in)
            CMD_MOV: res_s = val2_s;
            CMD_MVN: res_s = ~val2_s;
            CMD_AND: res_s = val_rn & val2_s;
            CMD_ORR: res_s = val_rn | val2_s;
            CMD_EOR: res_s = val_rn ^ val2_s;
            CMD_ADD, CMD_ADC: begin
               sum_s = {1'b0, val_rn} + {1'b0, val2_s}
                     + ((exe_command_in == CMD_ADC) ? (DATA_W+1)'(status_reg_in[NZCV_C]) : '0);
               res_s = sum_s[DATA_W-1:0];
               c_s   = sum_s[DATA_W];
               v_s   = (val_rn[DATA_W-1] == val2_s[DATA_W-1]) && (res_s[DATA_W-1] != val_rn[DATA_W-1]);
            end
            CMD_SUB, CMD_SBC: begin
               sum_s = {1'b0, val_rn} + {1'b0, ~val2_s}
                     + ((exe_command_in == CMD_SBC) ? (DATA_W+1)'(status_reg_in[NZCV_C]) : (DATA_W+1)'(1'b1));
               res_s = sum_s[DATA_W-1:0];
               c_s   = sum_s[DATA_W];
               v_s   = (val_rn[DATA_W-1] != val2_s[DATA_W-1]) && (res_s[DATA_W-1] != val_rn[DATA_W-1]);
            end
            default: res_s = '0;
         endcase
      end
      nzcv_s = {res_s[DATA_W-1], (res_s == '0), c_s, v_s};
   end

   iter_multiplier #(.DATA_W(DATA_W), .MUL_STEP(MUL_STEP)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start_s),
      .abort   (flush),
      .a       (val_rn),
      .b       (val2_s),
      .done    (mul_fin_s),
      .product (prod_s)
   );

   // FSM next state; flush always returns to IDLE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: if (mul_start_s) state_s = ST_MUL; else state_s = ST_IDLE;
         ST_MUL:  if (flush || mul_done_s) state_s = ST_IDLE; else state_s = ST_MUL;
         default: state_s = ST_IDLE;
      endcase
   end

   // State and busy registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         busy    <= 1'b0;
      end else begin
         state_r <= state_s;
         busy    <= (state_s == ST_MUL);
      end
   end

   // Side-band of a multiply held until its product is ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         {p_wb_r, p_mr_r, p_mw_r, p_s_r} <= 4'b0000;
         p_dest_r   <= 4'd0;
         p_status_r <= 4'd0;
         p_rm_r     <= '0;
         p_br_r     <= '0;
      end else if (mul_start_s) begin
         {p_wb_r, p_mr_r, p_mw_r, p_s_r} <= {wb_en_in, mem_read_in, mem_write_in, s_in};
         p_dest_r   <= dest;
         p_status_r <= status_reg_in;
         p_rm_r     <= val_rm;
         p_br_r     <= br_s;
      end
   end

   // EX/MEM output register; flush wins over both a new load and a finishing multiply.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid       <= 1'b0;
         {wb_en_out, mem_read_out, mem_write_out, status_we_out} <= 4'b0000;
         dest_out        <= 4'd0;
         status_bits_out <= 4'd0;
         alu_res         <= '0;
         val_rm_out      <= '0;
         branch_address  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept_s && !is_mul_s) begin
         out_valid       <= 1'b1;
         {wb_en_out, mem_read_out, mem_write_out} <= {wb_en_in, mem_read_in, mem_write_in};
         status_we_out   <= s_in && !is_mem_s;
         status_bits_out <= (s_in && !is_mem_s) ? nzcv_s : status_reg_in;
         dest_out        <= dest;
         alu_res         <= res_s;
         val_rm_out      <= val_rm;
         branch_address  <= br_s;
      end else if (mul_done_s) begin
         out_valid       <= 1'b1;
         {wb_en_out, mem_read_out, mem_write_out} <= {p_wb_r, p_mr_r, p_mw_r};
         status_we_out   <= p_s_r;
         status_bits_out <= p_s_r ? {prod_s[DATA_W-1], (prod_s == '0), p_status_r[NZCV_C], p_status_r[NZCV_V]}
                                  : p_status_r;
         dest_out        <= p_dest_r;
         alu_res         <= prod_s;
         val_rm_out      <= p_rm_r;
         branch_address  <= p_br_r;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Directed plus randomized bench for exe_stage_pipe against an arithmetic reference model.
module tb_exe_stage_pipe;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, wb_en_in, mem_read_in, mem_write_in, I, s_in;
   logic [3:0]  exe_command_in, dest, status_reg_in;
   logic [11:0] shift_operand;
   logic [23:0] signed_immediate_24;
   logic [31:0] PC_in, val_rn, val_rm;
   logic        out_valid, out_ready, wb_en_out, mem_read_out, mem_write_out, status_we_out, busy;
   logic [3:0]  dest_out, status_bits_out;
   logic [31:0] alu_res, val_rm_out, branch_address;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   exe_stage_pipe #(.DATA_W(32), .IMM_W(24), .MUL_STEP(4)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .wb_en_in(wb_en_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .I(I), .s_in(s_in),
      .exe_command_in(exe_command_in), .shift_operand(shift_operand), .dest(dest),
      .signed_immediate_24(signed_immediate_24), .PC_in(PC_in), .val_rn(val_rn), .val_rm(val_rm),
      .status_reg_in(status_reg_in), .out_valid(out_valid), .out_ready(out_ready),
      .wb_en_out(wb_en_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
      .status_we_out(status_we_out), .dest_out(dest_out), .status_bits_out(status_bits_out),
      .alu_res(alu_res), .val_rm_out(val_rm_out), .branch_address(branch_address), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      longint unsigned w;
      n = n % 32;
      w = x;
      w = (w >> n) | (w << (32 - n));
      return w[31:0];
   endfunction

   function automatic void model(input logic [3:0] cmd, input bit imm, input bit mem, input logic [11:0] so,
                                 input logic [31:0] rn, input logic [31:0] rm, input logic [3:0] st,
                                 output logic [31:0] res, output logic [3:0] nzcv);
      logic [31:0]        v2;
      logic signed [31:0] srm;
      longint unsigned    u;
      longint             ua, ub, sres, bor;
      bit                 c, v;
      int                 amt;
      c = st[1];
      v = st[0];
      amt = int'(so[11:7]);
      if (imm) v2 = rotr({24'd0, so[7:0]}, 2 * int'(so[11:8]));
      else if (mem) v2 = {20'd0, so};
      else begin
         case (so[6:5])
            2'd0: v2 = rm << amt;
            2'd1: v2 = rm >> amt;
            2'd2: begin srm = rm; srm = srm >>> amt; v2 = srm; end
            default: v2 = rotr(rm, amt);
         endcase
      end
      ua = rn;
      ub = v2;
      u = 64'd0;
      if (mem) u = ua + ub;
      else begin
         case (cmd)
            4'b0001: u = ub;
            4'b1001: u = ~ub;
            4'b0110: u = ua & ub;
            4'b0111: u = ua | ub;
            4'b1000: u = ua ^ ub;
            4'b1010: u = ua * ub;
            4'b0010, 4'b0011: begin
               bor = (cmd == 4'b0011) ? longint'(st[1]) : 64'sd0;
               u = ua + ub + bor;
               c = (u >= 64'd4294967296);
               sres = longint'($signed(rn)) + longint'($signed(v2)) + bor;
               v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            4'b0100, 4'b0101: begin
               bor = (cmd == 4'b0101) ? longint'(!st[1]) : 64'sd0;
               c = (ua >= ub + bor);
               u = ua - ub - bor;
               sres = longint'($signed(rn)) - longint'($signed(v2)) - bor;
               v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            default: u = 64'd0;
         endcase
      end
      res = u[31:0];
      nzcv = {res[31], res == 32'd0, c, v};
   endfunction

   task automatic drive(input logic [3:0] cmd, input bit imm, input bit mr, input bit mw, input bit s,
                        input logic [11:0] so, input logic [31:0] rn, input logic [31:0] rm,
                        input logic [31:0] pc, input logic [23:0] bimm, input logic [3:0] st);
      exe_command_in = cmd; I = imm; mem_read_in = mr; mem_write_in = mw; s_in = s;
      shift_operand = so; val_rn = rn; val_rm = rm; PC_in = pc; signed_immediate_24 = bimm;
      status_reg_in = st; in_valid = 1'b1;
   endtask

   // Issue one op, wait (bounded) for its result and compare everything against the model.
   task automatic send_check(input string tag, input logic [3:0] cmd, input bit imm, input bit mr, input bit mw,
                             input bit s, input logic [11:0] so, input logic [31:0] rn, input logic [31:0] rm,
                             input logic [31:0] pc, input logic [23:0] bimm, input logic [3:0] st);
      logic [31:0] e_res, e_br;
      logic [3:0]  e_nzcv, e_bits, dst;
      bit          e_we, wb;
      int          e_lat, cyc;
      longint      off, t;
      model(cmd, imm, mr || mw, so, rn, rm, st, e_res, e_nzcv);
      e_we   = s && !(mr || mw);
      e_bits = e_we ? e_nzcv : st;
      e_lat  = (cmd == 4'b1010 && !(mr || mw)) ? 9 : 1;
      off = bimm;
      if (bimm[23]) off = off - 64'sd16777216;
      t = longint'(pc) + off * 4;
      e_br = t[31:0];
      dst = 4'($urandom_range(0, 15));
      wb  = 1'($urandom_range(0, 1));
      drive(cmd, imm, mr, mw, s, so, rn, rm, pc, bimm, st);
      dest = dst; wb_en_in = wb;
      chk({tag, "_in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 40) begin
         if (e_lat > 1) begin
            chk({tag, "_busy_mid"}, busy, 1);
            chk({tag, "_ready_mid"}, in_ready, 0);
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_latency"}, cyc, e_lat);
      chk({tag, "_res"}, alu_res, e_res);
      chk({tag, "_nzcv"}, status_bits_out, e_bits);
      chk({tag, "_we"}, status_we_out, e_we);
      chk({tag, "_ctl"}, {wb_en_out, mem_read_out, mem_write_out, dest_out}, {wb, mr, mw, dst});
      chk({tag, "_rm"}, val_rm_out, rm);
      chk({tag, "_br"}, branch_address, e_br);
      chk({tag, "_busy_end"}, busy, 0);
   endtask

   initial begin
      logic [3:0] cmds [12];
      cmds = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
               4'b0110, 4'b0111, 4'b1000, 4'b1010, 4'b0000, 4'b1111};
      rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
      drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 32'd0, 32'd0, 32'd0, 24'd0, 4'd0);
      in_valid = 1'b0; dest = 4'd0; wb_en_in = 1'b0;

      // Reset state
      @(posedge clk); #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", {alu_res, branch_address}, 64'd0);
      chk("rst_misc", {val_rm_out, dest_out, status_bits_out, status_we_out, wb_en_out, mem_read_out, mem_write_out},
          {32'd0, 4'd0, 4'd0, 4'd0});
      chk("rst_in_ready", in_ready, 1);
      rst = 1'b1;

      // Directed examples
      send_check("add_ovf", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 12'h001, 32'h7FFF_FFFF, 32'd0, 32'd0, 24'd0, 4'b0000);
      chk("add_ovf_const", {alu_res, status_bits_out}, {32'h8000_0000, 4'b1001});
      send_check("sub_zero", 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 32'd5, 32'd5, 32'd0, 24'd0, 4'b0000);
      chk("sub_zero_const", {alu_res, status_bits_out}, {32'd0, 4'b0110});
      send_check("mov_rot", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 12'h4FF, 32'd0, 32'd0, 32'd0, 24'd0, 4'b0000);
      chk("mov_rot_const", alu_res, 32'hFF00_0000);
      send_check("mul_42", 4'b1010, 1'b1, 1'b0, 1'b0, 1'b1, 12'h006, 32'd7, 32'd0, 32'd0, 24'd0, 4'b0011);
      chk("mul_42_const", alu_res, 32'd42);
      send_check("mem_ld", 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1, 12'hABC, 32'h1000, 32'd9, 32'd0, 24'd0, 4'b1010);

      // Back-to-back throughput of one op per cycle
      for (int i = 1; i <= 4; i++) begin
         drive(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 12'(i), 32'(i * 16), 32'd0, 32'd0, 24'd0, 4'd0);
         @(posedge clk); #1;
         chk("b2b_valid", out_valid, 1);
         chk("b2b_res", alu_res, 32'(i * 17));
      end
      in_valid = 1'b0;
      @(posedge clk); #1;

      // Branch target and output stall
      out_ready = 1'b0;
      drive(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 12'h002, 32'd1, 32'd0, 32'h100, 24'hFF_FFFF, 4'd0);
      @(posedge clk); #1;
      chk("br_valid", out_valid, 1);
      chk("br_addr", branch_address, 32'h0000_00FC);
      drive(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 12'h055, 32'd0, 32'd0, 32'h800, 24'd4, 4'd0);
      for (int i = 0; i < 3; i++) begin
         chk("stall_in_ready", in_ready, 0);
         @(posedge clk); #1;
         chk("stall_hold", {out_valid, alu_res, branch_address}, {1'b1, 32'd3, 32'h0000_00FC});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_release", out_valid, 0);

      // Flush during multiply
      drive(4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 12'h006, 32'd7, 32'd0, 32'd0, 24'd0, 4'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("flush_busy_pre", busy, 1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_idle", {busy, out_valid, in_ready}, {1'b0, 1'b0, 1'b1});
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            seen |= out_valid;
         end
         chk("flush_no_valid", seen, 0);
      end

      // Flush coinciding with multiply completion
      drive(4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 12'h003, 32'd9, 32'd0, 32'd0, 24'd0, 4'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_done", {out_valid, busy}, {1'b0, 1'b0});
      @(posedge clk); #1;
      chk("flush_done_after", out_valid, 0);

      // Flush beats a simultaneous accept
      drive(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 12'h011, 32'd1, 32'd0, 32'd0, 24'd0, 4'd0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_accept", out_valid, 0);

      // Randomized operations
      for (int n = 0; n < 80; n++) begin
         logic [3:0] cmd;
         bit mr, mw;
         cmd = cmds[$urandom_range(0, 11)];
         mr = ($urandom_range(0, 4) == 0);
         mw = !mr && ($urandom_range(0, 5) == 0);
         send_check("rnd", cmd, 1'($urandom_range(0, 1)), mr, mw, 1'($urandom_range(0, 1)),
                    12'($urandom), $urandom, $urandom, $urandom, 24'($urandom), 4'($urandom));
      end

      // Asynchronous reset in the middle of a multiply
      drive(4'b1010, 1'b1, 1'b0, 1'b0, 1'b1, 12'h005, 32'd3, 32'h1234, 32'h400, 24'd1, 4'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("arst_valid_busy", {out_valid, busy}, {1'b0, 1'b0});
      chk("arst_data", {alu_res, branch_address}, 64'd0);
      chk("arst_misc", {val_rm_out, dest_out, status_bits_out, status_we_out, wb_en_out, mem_read_out, mem_write_out},
          {32'd0, 4'd0, 4'd0, 4'd0});
      @(posedge clk); #1;
      rst = 1'b1;
      send_check("post_rst", 4'b0101, 1'b0, 1'b0, 1'b0, 1'b1, 12'h0A0, 32'd10, 32'd3, 32'h40, 24'h80_0000, 4'b0010);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
